// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its user: serial line in, received byte and status out.
interface uart_rx_if;
   logic       rx_in;
   logic       p_sel;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      output rx_in,
      output p_sel,
      input  rx_data,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      input  rx_busy
   );

   modport slave (
      input  rx_in,
      input  p_sel,
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      output rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit (even/odd chosen per frame), one stop bit.
// Bits are sampled mid-period after a 2-flop synchronizer; results are presented with a 1-cycle strobe.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input logic     clk,
   input logic     reset,
   uart_rx_if.slave bus
);

   localparam int unsigned CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HalfBit = CLKS_PER_BIT / 2;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            psel_q, psel_d;
   logic            par_bit_q, par_bit_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            parity_err_q, parity_err_d;
   logic            frame_err_q, frame_err_d;

   logic sync1_q, rx_s_q, rx_prev_q;
   logic half_done, bit_done, exp_par;

   // rx_prev_q tracks rx_s every cycle so a low stop bit cannot look like a new start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= bus.rx_in;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end

   assign half_done = (clk_cnt_q == CntW'(HalfBit - 1));
   assign bit_done  = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
   assign exp_par   = psel_q ? (^shift_q) : ~(^shift_q);

   always_comb begin
      state_d      = state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      psel_d       = psel_q;
      par_bit_d    = par_bit_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      unique case (state_q)
         StIdle: begin
            if (rx_prev_q && !rx_s_q) begin
               state_d   = StStart;
               clk_cnt_d = '0;
               psel_d    = bus.p_sel;
            end
         end
         StStart: begin
            if (half_done) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = rx_s_q ? StIdle : StData;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StData: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = StParity;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StParity: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               par_bit_d = rx_s_q;
               state_d   = StStop;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (bit_done) begin
               clk_cnt_d    = '0;
               state_d      = StIdle;
               rx_valid_d   = 1'b1;
               rx_data_d    = shift_q;
               parity_err_d = par_bit_q ^ exp_par;
               frame_err_d  = ~rx_s_q;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         psel_q       <= 1'b0;
         par_bit_q    <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         psel_q       <= psel_d;
         par_bit_q    <= par_bit_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial line driver pushes expected frames to a scoreboard,
// a negedge monitor captures every rx_valid strobe, and each test task drains and compares.
module tb_uart_rx;

   localparam int unsigned CPB = 16;

   logic clk = 1'b0;
   logic reset;
   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic        perr;
      logic        ferr;
      int unsigned cyc;
   } rec_t;

   rec_t        exp_q[$];
   rec_t        obs_q[$];
   rec_t        mon_r;
   int unsigned cyc = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         mon_r.data = bus.rx_data;
         mon_r.perr = bus.parity_err;
         mon_r.ferr = bus.frame_err;
         mon_r.cyc  = cyc;
         obs_q.push_back(mon_r);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic par_of(input logic [7:0] d, input logic even);
      return even ? (^d) : ~(^d);
   endfunction

   task automatic send_bit(input logic b);
      bus.rx_in = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Behavioural transmitter; expectation uses p_sel as it stands at the start bit.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic flip);
      rec_t e;
      e.data = d;
      e.perr = (par !== par_of(d, bus.p_sel));
      e.ferr = ~stop;
      e.cyc  = cyc;
      exp_q.push_back(e);
      send_bit(1'b0);
      if (flip) bus.p_sel = ~bus.p_sel;
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
   endtask

   task automatic idle(input int unsigned n);
      bus.rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.rx_in = 1'b1;
      bus.p_sel = 1'b1;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_state: got data=%h v=%b pe=%b fe=%b busy=%b, need all zero",
                  bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy);
      end
      reset = 1'b0;
      idle(2 * CPB);
   endtask

   task automatic test_basic();
      rec_t e, o;
      bus.p_sel = 1'b1;
      send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
      idle(CPB);
      vectors++;
      if (obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL basic_count: got %0d strobes, need 1", obs_q.size());
      end
      if (obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o.data !== 8'hAA || o.perr !== 1'b0 || o.ferr !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_frame: got %h pe=%b fe=%b, need aa pe=0 fe=0",
                     o.data, o.perr, o.ferr);
         end
         vectors++;
         if (o.cyc - e.cyc < 170 || o.cyc - e.cyc > 172) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, need 171 +/-1", o.cyc - e.cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      rec_t e, o;
      int unsigned n;
      bus.p_sel = 1'b0;
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      // 0x0F has four set bits, so odd parity wants 1; the second 0x0F carries a wrong 0.
      send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.p_sel = 1'($urandom_range(0, 1));
         n = $urandom_range(0, 255);
         send_frame(8'(n), par_of(8'(n), bus.p_sel) ^ ($urandom_range(0, 2) == 0), 1'b1, 1'b0);
      end
      for (int i = 0; i < 4 * CPB && obs_q.size() < exp_q.size(); i++) @(posedge clk);
      idle(CPB);
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d strobes, need %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o.data !== e.data || o.perr !== e.perr || o.ferr !== e.ferr) begin
            miscompares++;
            $display("FAIL b2b_frame: got %h pe=%b fe=%b, need %h pe=%b fe=%b",
                     o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_frame_err();
      rec_t e, o;
      bus.p_sel = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      bus.rx_in = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      #1;
      vectors++;
      if (bus.rx_busy !== 1'b0 || obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL ferr_no_restart: got busy=%b strobes=%0d, need busy=0 strobes=1",
                  bus.rx_busy, obs_q.size());
      end
      idle(2 * CPB);
      send_frame(8'h81, 1'b0, 1'b1, 1'b0);
      idle(CPB);
      vectors++;
      if (obs_q.size() != 2) begin
         miscompares++;
         $display("FAIL ferr_count: got %0d strobes, need 2", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o.data !== e.data || o.perr !== e.perr || o.ferr !== e.ferr) begin
            miscompares++;
            $display("FAIL ferr_frame: got %h pe=%b fe=%b, need %h pe=%b fe=%b",
                     o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_glitch();
      int unsigned n = 0;
      logic        seen_busy;
      bus.rx_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.rx_in = 1'b1;
      seen_busy = bus.rx_busy;
      while (bus.rx_busy === 1'b1 && n < CPB / 2 + 3) begin
         @(posedge clk);
         #1;
         n++;
      end
      vectors++;
      if (seen_busy !== 1'b1 || bus.rx_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_busy: got seen=%b busy=%b after %0d cycles, need seen=1 busy=0",
                  seen_busy, bus.rx_busy, n);
      end
      idle(2 * CPB);
      vectors++;
      if (obs_q.size() != 0 || bus.rx_data !== 8'h81) begin
         miscompares++;
         $display("FAIL glitch_hold: got strobes=%0d data=%h, need 0 strobes data=81",
                  obs_q.size(), bus.rx_data);
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid();
      rec_t e, o;
      logic [7:0] d = 8'h5A;
      bus.p_sel = 1'b1;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      bus.rx_in = d[4];
      repeat (CPB / 2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy} !== 12'h000) begin
         miscompares++;
         $display("FAIL midreset_state: got data=%h v=%b pe=%b fe=%b busy=%b, need all zero",
                  bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy);
      end
      reset = 1'b0;
      idle(2 * CPB);
      vectors++;
      if (obs_q.size() != 0) begin
         miscompares++;
         $display("FAIL midreset_nopulse: got %0d strobes, need 0", obs_q.size());
      end
      obs_q.delete();
      send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
      idle(CPB);
      vectors++;
      if (obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL midreset_count: got %0d strobes, need 1", obs_q.size());
      end
      if (obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o.data !== e.data || o.perr !== e.perr || o.ferr !== e.ferr) begin
            miscompares++;
            $display("FAIL midreset_frame: got %h pe=%b fe=%b, need %h pe=%b fe=%b",
                     o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_psel_latch();
      rec_t e, o;
      bus.p_sel = 1'b1;
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      bus.p_sel = 1'b1;
      bus.p_sel = 1'b1;
      send_frame(8'hAA, par_of(8'hAA, bus.p_sel), 1'b1, 1'b0);
      idle(CPB);
      vectors++;
      if (obs_q.size() != 2) begin
         miscompares++;
         $display("FAIL psel_count: got %0d strobes, need 2", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         vectors++;
         if (o.data !== e.data || o.perr !== e.perr || o.ferr !== e.ferr) begin
            miscompares++;
            $display("FAIL psel_loopback_frame: got %h pe=%b fe=%b, need %h pe=%b fe=%b",
                     o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      bus.rx_in = 1'b1;
      bus.p_sel = 1'b1;
      reset     = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_psel_latch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
